// File: rtl/vec_pkg.sv
// Shared types for the vector execute stage: opcodes, FSM states, lane geometry.
package vec_pkg;

  localparam int LANES     = 8;
  localparam int N_DEFAULT = 20;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_XOR  = 3'b010,
    OP_AND  = 3'b011,
    OP_SLL  = 3'b100,
    OP_SRL  = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } vec_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } vec_state_e;

endpackage

// File: rtl/vec_lane_alu.sv
// One-lane combinational ALU for every opcode except MUL (MUL lanes come from the shared multipliers).
// Zero latency, no flow control.
module vec_lane_alu
  import vec_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic [2:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] res_o
);

  logic [4:0] shamt;
  logic       shift_oob;

  assign shamt     = b_i[4:0];
  // Shifting by the full lane width or more must clear the lane.
  assign shift_oob = (32'(shamt) >= 32'(N));

  always_comb begin
    res_o = a_i;
    case (vec_op_e'(op_i))
      OP_ADD:  res_o = a_i + b_i;
      OP_SUB:  res_o = a_i - b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_AND:  res_o = a_i & b_i;
      OP_SLL:  res_o = shift_oob ? '0 : (a_i << shamt);
      OP_SRL:  res_o = shift_oob ? '0 : (a_i >> shamt);
      default: res_o = a_i;
    endcase
  end

endmodule

// File: rtl/vec_exec_stage.sv
// Vector execute stage: 8 lanes, non-MUL ops write back after 1 cycle, MUL after 5 cycles
// using two shared multipliers over four steps; in_ready drops while a MUL is in flight.
module vec_exec_stage
  import vec_pkg::*;
#(
  parameter int N = N_DEFAULT
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [2:0]                  op,
  input  logic [3:0]                  dst,
  input  logic [LANES-1:0][N-1:0]     a,
  input  logic [LANES-1:0][N-1:0]     b,
  output logic                        we3,
  output logic [3:0]                  ra3,
  output logic [LANES-1:0][N-1:0]     wd3,
  output logic                        busy
);

  vec_state_e                state_q, state_d;
  logic [1:0]                k_q, k_d;
  logic [LANES-1:0][N-1:0]   a_q, a_d, b_q, b_d, acc_q, acc_d;
  logic [3:0]                dst_q, dst_d;
  logic                      we3_q, we3_d;
  logic [3:0]                ra3_q, ra3_d;
  logic [LANES-1:0][N-1:0]   wd3_q, wd3_d;

  logic [LANES-1:0][N-1:0]   alu_res;
  logic [2:0]                lo_idx, hi_idx;
  logic [N-1:0]              prod_lo, prod_hi;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_lane_alu #(.N(N)) u_alu (
      .op_i  (op),
      .a_i   (a[i]),
      .b_i   (b[i]),
      .res_o (alu_res[i])
    );
  end

  // Two multipliers shared across the four MUL steps; N-bit context keeps the low N bits.
  assign lo_idx  = {k_q, 1'b0};
  assign hi_idx  = {k_q, 1'b1};
  assign prod_lo = a_q[lo_idx] * b_q[lo_idx];
  assign prod_hi = a_q[hi_idx] * b_q[hi_idx];

  assign in_ready = (state_q == ST_IDLE);
  assign busy     = (state_q == ST_MUL);
  assign we3      = we3_q;
  assign ra3      = ra3_q;
  assign wd3      = wd3_q;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    dst_d   = dst_q;
    acc_d   = acc_q;
    we3_d   = 1'b0;
    ra3_d   = ra3_q;
    wd3_d   = wd3_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (vec_op_e'(op) == OP_MUL) begin
            a_d     = a;
            b_d     = b;
            dst_d   = dst;
            k_d     = 2'd0;
            state_d = ST_MUL;
          end else begin
            we3_d = 1'b1;
            ra3_d = dst;
            wd3_d = alu_res;
          end
        end
      end
      ST_MUL: begin
        acc_d[lo_idx] = prod_lo;
        acc_d[hi_idx] = prod_hi;
        k_d           = k_q + 2'd1;
        if (k_q == 2'd3) begin
          we3_d   = 1'b1;
          ra3_d   = dst_q;
          wd3_d   = acc_d;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      k_q     <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      dst_q   <= '0;
      acc_q   <= '0;
      we3_q   <= 1'b0;
      ra3_q   <= '0;
      wd3_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      dst_q   <= dst_d;
      acc_q   <= acc_d;
      we3_q   <= we3_d;
      ra3_q   <= ra3_d;
      wd3_q   <= wd3_d;
    end
  end

endmodule

// File: tb/tb_vec_exec_stage.sv
// Directed plus randomized bench for vec_exec_stage against a lane-arithmetic reference model.
module tb_vec_exec_stage;

  localparam int N = 20;
  localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, AND = 3'd3,
                         SLL = 3'd4, SRL = 3'd5, MUL = 3'd6, PASS = 3'd7;

  typedef logic [7:0][N-1:0] vec_t;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] op;
  logic [3:0] dst;
  vec_t       a, b;
  logic       we3;
  logic [3:0] ra3;
  vec_t       wd3;
  logic       busy;

  int errors = 0;
  int checks = 0;

  vec_exec_stage #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .dst      (dst),
    .a        (a),
    .b        (b),
    .we3      (we3),
    .ra3      (ra3),
    .wd3      (wd3),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t model(input logic [2:0] o, input vec_t va, input vec_t vb);
    vec_t r;
    longint unsigned m, x, y, z, sh;
    m = 64'd1 << N;
    for (int i = 0; i < 8; i++) begin
      x  = 64'(va[i]);
      y  = 64'(vb[i]);
      sh = y % 32;
      case (o)
        ADD:     z = (x + y) % m;
        SUB:     z = (x + m - y) % m;
        XOR:     z = x ^ y;
        AND:     z = x & y;
        SLL:     z = (sh >= N) ? 0 : ((x << sh) % m);
        SRL:     z = (sh >= N) ? 0 : (x >> sh);
        MUL:     z = (x * y) % m;
        default: z = x;
      endcase
      r[i] = z[N-1:0];
    end
    return r;
  endfunction

  function automatic vec_t rand_vec();
    vec_t v;
    for (int i = 0; i < 8; i++) v[i] = N'($urandom_range(0, (1 << N) - 1));
    return v;
  endfunction

  task automatic chk(input string tag, input logic [8*N-1:0] got, input logic [8*N-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [2:0] o, input logic [3:0] d, input vec_t va, input vec_t vb);
    in_valid = 1'b1;
    op       = o;
    dst      = d;
    a        = va;
    b        = vb;
    @(negedge clk);
  endtask

  task automatic chk_write(input string tag, input logic [3:0] d, input vec_t exp);
    chk({tag, ".we3"}, 160'(we3), 160'(1'b1));
    chk({tag, ".ra3"}, 160'(ra3), 160'(d));
    chk({tag, ".wd3"}, wd3, exp);
  endtask

  initial begin : stim
    vec_t va, vb, exp, last;
    logic [2:0] o;
    logic [3:0] d;

    reset = 1'b1; in_valid = 1'b0; op = '0; dst = '0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    chk("rst.we3", 160'(we3), 160'(1'b0));
    chk("rst.ra3", 160'(ra3), 160'(4'd0));
    chk("rst.wd3", wd3, '0);
    chk("rst.busy", 160'(busy), 160'(1'b0));
    reset = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 160'(in_ready), 160'(1'b1));

    for (int i = 0; i < 8; i++) begin va[i] = N'(i); vb[i] = N'(10); exp[i] = N'(i + 10); end
    send(ADD, 4'd3, va, vb);
    chk_write("add", 4'd3, exp);

    for (int i = 0; i < 8; i++) begin va[i] = '0; vb[i] = N'(1); exp[i] = N'(20'hFFFFF); end
    send(SUB, 4'd4, va, vb);
    chk_write("sub_wrap", 4'd4, exp);

    for (int i = 0; i < 8; i++) begin
      va[i]  = N'(1);
      vb[i]  = N'(i * 4);
      exp[i] = (i < 5) ? N'(1 << (4 * i)) : '0;
    end
    send(SLL, 4'd5, va, vb);
    chk_write("sll_oob", 4'd5, exp);
    last = exp;
    in_valid = 1'b0;
    @(negedge clk);
    chk("hold.we3", 160'(we3), 160'(1'b0));
    chk("hold.wd3", wd3, last);

    // Three back-to-back ops, one write pulse each.
    va = rand_vec(); vb = rand_vec();
    send(XOR, 4'd1, va, vb);
    chk_write("b2b_xor", 4'd1, model(XOR, va, vb));
    va = rand_vec(); vb = rand_vec();
    send(AND, 4'd2, va, vb);
    chk_write("b2b_and", 4'd2, model(AND, va, vb));
    va = rand_vec(); vb = rand_vec();
    send(PASS, 4'd8, va, vb);
    chk_write("b2b_pass", 4'd8, model(PASS, va, vb));
    in_valid = 1'b0;
    @(negedge clk);
    chk("b2b.idle_we3", 160'(we3), 160'(1'b0));

    // MUL with operands disturbed after acceptance and a competing bundle offered while busy.
    for (int i = 0; i < 8; i++) begin va[i] = N'(3); vb[i] = N'(5); exp[i] = N'(15); end
    send(MUL, 4'd7, va, vb);
    va = rand_vec(); vb = rand_vec();
    in_valid = 1'b1; op = ADD; dst = 4'd1; a = va; b = vb;
    for (int c = 1; c <= 4; c++) begin
      chk($sformatf("mul.in_ready_t%0d", c), 160'(in_ready), 160'(1'b0));
      chk($sformatf("mul.busy_t%0d", c), 160'(busy), 160'(1'b1));
      chk($sformatf("mul.we3_t%0d", c), 160'(we3), 160'(1'b0));
      @(negedge clk);
    end
    chk_write("mul", 4'd7, exp);
    chk("mul.in_ready_t5", 160'(in_ready), 160'(1'b1));
    chk("mul.busy_t5", 160'(busy), 160'(1'b0));
    @(negedge clk);
    chk_write("after_mul_add", 4'd1, model(ADD, va, vb));
    in_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of a MUL aborts it.
    send(MUL, 4'd9, rand_vec(), rand_vec());
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort.busy", 160'(busy), 160'(1'b0));
    chk("abort.in_ready", 160'(in_ready), 160'(1'b1));
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("abort.we3_%0d", c), 160'(we3), 160'(1'b0));
      @(negedge clk);
    end
    chk("abort.busy_after", 160'(busy), 160'(1'b0));

    // Reset wins over a simultaneous acceptance.
    in_valid = 1'b1; op = ADD; dst = 4'd5; a = rand_vec(); b = rand_vec(); reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    chk("rstprio.we3", 160'(we3), 160'(1'b0));
    @(negedge clk);
    chk("rstprio.we3_next", 160'(we3), 160'(1'b0));
    chk("rstprio.ra3", 160'(ra3), 160'(4'd0));

    // Randomized ops against the model.
    for (int it = 0; it < 150; it++) begin
      o  = 3'($urandom_range(0, 7));
      d  = 4'($urandom_range(0, 15));
      va = rand_vec();
      vb = rand_vec();
      exp = model(o, va, vb);
      send(o, d, va, vb);
      if (o == MUL) begin
        in_valid = 1'b0;
        a = rand_vec(); b = rand_vec();
        for (int c = 1; c <= 4; c++) begin
          chk($sformatf("rnd%0d.mul_we3_t%0d", it, c), 160'(we3), 160'(1'b0));
          @(negedge clk);
        end
      end
      chk_write($sformatf("rnd%0d.op%0d", it, o), d, exp);
      in_valid = 1'b0;
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        chk($sformatf("rnd%0d.gap_we3", it), 160'(we3), 160'(1'b0));
        chk($sformatf("rnd%0d.gap_wd3", it), wd3, exp);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vec_exec_stage.md
VEC_EXEC_STAGE -- requirements
Module: vec_exec_stage

Interface
REQ-001 The block SHALL have parameter N, default 20, meaning lane width in bits; lane count is fixed at 8.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit, meaning the operand/op bundle is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit, meaning the stage can accept a bundle this cycle.
REQ-006 The block SHALL have port op, input, 3 bits, the vector opcode.
REQ-007 The block SHALL have port dst, input, 4 bits, the destination vector register index.
REQ-008 The block SHALL have port a, input, [7:0][N-1:0], operand vector A (register-file rd1).
REQ-009 The block SHALL have port b, input, [7:0][N-1:0], operand vector B (register-file rd2).
REQ-010 The block SHALL have port we3, output, 1 bit, the register-file write enable.
REQ-011 The block SHALL have port ra3, output, 4 bits, the register-file write index.
REQ-012 The block SHALL have port wd3, output, [7:0][N-1:0], the register-file write data.
REQ-013 The block SHALL have port busy, output, 1 bit, high while a multiply is in progress.

Function
REQ-014 A bundle SHALL be accepted in a cycle where in_valid && in_ready is true; it SHALL be ignored otherwise.
REQ-015 Opcodes, all lane-wise and modulo 2^N: 000 ADD, 001 SUB (a-b), 010 XOR, 011 AND, 100 SLL a by b[4:0], 101 SRL a by b[4:0] (logical), 110 MUL (low N bits of a*b), 111 PASS a.
REQ-016 For SLL/SRL, a shift amount >= N SHALL yield 0 in that lane.
REQ-017 FSM states SHALL be IDLE and MUL; in_ready = 1 in IDLE, 0 in MUL; busy = (state==MUL).
REQ-018 Non-MUL ops accepted in cycle t SHALL produce we3=1, ra3=dst, wd3=result in cycle t+1 (registered, latency 1).
REQ-019 Back-to-back non-MUL ops SHALL be accepted every cycle with one we3 pulse per op.
REQ-020 Accepting MUL SHALL latch a, b, dst and move IDLE->MUL with lane counter k=0.
REQ-021 In MUL, each cycle SHALL compute lanes 2k and 2k+1 into an accumulation register, then k increments; k=3 is the last step.
REQ-022 MUL accepted in cycle t SHALL produce we3=1 with the full result in cycle t+5, with MUL->IDLE in the same cycle; the next bundle can be accepted in t+5.
REQ-023 we3 SHALL be a one-cycle pulse per accepted op; wd3/ra3 SHALL hold their last values when we3=0.
REQ-024 Operand changes on a/b after a MUL is accepted SHALL NOT affect its result.
REQ-025 The block SHALL apply no backpressure on the write side; the register file always accepts the write.

Reset
REQ-026 While reset is high: state=IDLE, k=0, we3=0, ra3=0, wd3=0, busy=0, and in_ready=1 in the cycle after reset.
REQ-027 Reset during MUL SHALL abort the operation and produce no write pulse.
REQ-028 Reset SHALL take priority over a simultaneous acceptance; the bundle SHALL be dropped.

Structure
REQ-029 The opcode enum, the FSM state enum, the lane count (8) and the default N SHALL reside in shared package vec_pkg.
REQ-030 A single combinational sub-module vec_lane_alu (one lane, non-MUL ops) SHALL be instantiated 8 times.
REQ-031 MUL SHALL use exactly two N x N multipliers, shared across steps.

Verification
REQ-032 Reset, then ADD lanes a=i, b=10 for i=0..7, dst=3 -> next cycle we3=1, ra3=3, wd3 lane i = i+10.
REQ-033 SUB with a=0, b=1 on all lanes, N=20 -> all lanes 0xFFFFF (wrap-around).
REQ-034 SLL with a=1, b lane i = i*4 (lane 7 = 28) -> lanes 1<<(4i) for i<5, lanes 5..7 = 0.
REQ-035 MUL with a=3, b=5 on all lanes, dst=7, accepted at t; a/b changed at t+1 -> in_ready=0 for t+1..t+4, we3 only at t+5, all lanes 15, ra3=7.
REQ-036 Back-to-back XOR, AND, PASS in three consecutive cycles -> three consecutive we3 pulses with the correct data each.
REQ-037 MUL accepted, then reset asserted at t+2 -> no we3 pulse; in_ready=1 and busy=0 after reset.
